// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: controller/PC side (master) and instr_fetch (slave).
interface instr_fetch_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
);
    logic [WIDTH-1:0]  pc;
    logic              jump_flag;
    logic              load_start;
    logic              load_done;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [WIDTH-1:0]  prog_data;
    logic              pc_reset_out;
    logic [WIDTH-1:0]  instr;
    logic [WIDTH-1:0]  instr_pc;
    logic              instr_valid;
    logic              halted;
    logic              fetch_fault;

    modport master (
        output pc, jump_flag, load_start, load_done, prog_we, prog_addr, prog_data,
        input  pc_reset_out, instr, instr_pc, instr_valid, halted, fetch_fault
    );

    modport slave (
        input  pc, jump_flag, load_start, load_done, prog_we, prog_addr, prog_data,
        output pc_reset_out, instr, instr_pc, instr_valid, halted, fetch_fault
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch with loadable program memory; LOAD/RUN/HALT sequencing parks the PC.
// Latency: pc to instr is 1 cycle; no backpressure, decode takes one instruction per cycle.
module instr_fetch #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 28,
    parameter int               ADDR_W    = 5,
    parameter int               LAST_ADDR = 27,
    parameter logic [WIDTH-1:0] NOP       = '0
) (
    input  logic          clk,
    input  logic          fetch_reset,
    instr_fetch_if.slave  bus
);
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    localparam logic [WIDTH-1:0] DEPTH_PC  = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] LAST_PC   = WIDTH'(LAST_ADDR);
    localparam logic [ADDR_W:0]  DEPTH_WR  = (ADDR_W+1)'(DEPTH);

    state_t           state;
    logic             pc_reset_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] instr_pc_q;
    logic             instr_valid_q;
    logic             halted_q;
    logic             fault_q;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;

    // Program memory keeps its contents across reset.
    assign wr_en = (state == S_LOAD) && bus.prog_we && ({1'b0, bus.prog_addr} < DEPTH_WR);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or posedge fetch_reset) begin
        if (fetch_reset) begin
            state         <= S_LOAD;
            pc_reset_q    <= 1'b1;
            instr_q       <= NOP;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    instr_valid_q <= 1'b0;
                    instr_q       <= NOP;
                    if (bus.load_done) begin
                        state      <= S_RUN;
                        pc_reset_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.load_start) begin
                        state         <= S_LOAD;
                        pc_reset_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                        instr_q       <= NOP;
                        fault_q       <= 1'b0;
                    end else if (bus.jump_flag) begin
                        // PC is loading its target this edge; current pc is wrong-path.
                        instr_valid_q <= 1'b0;
                        instr_q       <= NOP;
                    end else if (bus.pc >= DEPTH_PC) begin
                        instr_valid_q <= 1'b0;
                        instr_q       <= NOP;
                        fault_q       <= 1'b1;
                    end else begin
                        instr_q       <= mem[bus.pc[ADDR_W-1:0]];
                        instr_pc_q    <= bus.pc;
                        instr_valid_q <= 1'b1;
                        if (bus.pc == LAST_PC) begin
                            state      <= S_HALT;
                            pc_reset_q <= 1'b1;
                            halted_q   <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    instr_valid_q <= 1'b0;
                    instr_q       <= NOP;
                    if (bus.load_start) begin
                        state      <= S_LOAD;
                        pc_reset_q <= 1'b1;
                        halted_q   <= 1'b0;
                        fault_q    <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_LOAD;
                    pc_reset_q    <= 1'b1;
                    instr_valid_q <= 1'b0;
                    instr_q       <= NOP;
                    halted_q      <= 1'b0;
                    fault_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_reset_out = pc_reset_q;
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.instr_valid  = instr_valid_q;
    assign bus.halted       = halted_q;
    assign bus.fetch_fault  = fault_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC model drives pc, scoreboard queue holds expected fetches.
module tb_instr_fetch;
    localparam int WIDTH     = 16;
    localparam int DEPTH     = 28;
    localparam int ADDR_W    = 5;
    localparam int LAST_ADDR = 27;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        fetch_reset;
    logic [15:0] pc_q;
    logic        pc_force;
    logic [15:0] pc_force_val;
    logic [15:0] jmp_tgt;
    logic        mon_en;
    logic [15:0] exp_mem [DEPTH];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    instr_fetch #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .LAST_ADDR(LAST_ADDR), .NOP(16'h0000)
    ) dut (
        .clk(clk),
        .fetch_reset(fetch_reset),
        .bus(bus)
    );

    // Program counter: sync reset, jump load, saturating increment.
    always @(posedge clk) begin
        if (bus.pc_reset_out)              pc_q <= 16'd0;
        else if (bus.jump_flag)            pc_q <= jmp_tgt;
        else if (pc_q != 16'(LAST_ADDR))   pc_q <= pc_q + 16'd1;
    end
    assign bus.pc = pc_force ? pc_force_val : pc_q;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Monitor: every valid output pops one expected fetch; idle outputs must be NOP.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (bus.instr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_valid", {16'd0, bus.instr_pc}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("instr_pc", {16'd0, bus.instr_pc}, {16'd0, mon_e.pc});
                    check_val("instr", {16'd0, bus.instr}, {16'd0, mon_e.dat});
                end
            end else begin
                check_val("idle_nop", {16'd0, bus.instr}, 32'd0);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.pc  = 16'(a);
        e.dat = exp_mem[a];
        exp_q.push_back(e);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push_exp(i);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        cycle();
        bus.prog_we   = 1'b0;
    endtask

    task automatic start_run(input int hi);
        bus.load_done = 1'b1;
        if (hi >= 0) push_range(0, hi);
        cycle();
        bus.load_done = 1'b0;
        check_val("run_entry_prst", {31'd0, bus.pc_reset_out}, 32'd0);
        check_val("run_entry_vld", {31'd0, bus.instr_valid}, 32'd0);
    endtask

    task automatic drain_and_halt(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycle();
            n++;
        end
        check_val({tag, "_drain"}, exp_q.size(), 32'd0);
        cycle();
        check_val({tag, "_halted"}, {31'd0, bus.halted}, 32'd1);
        check_val({tag, "_vld"}, {31'd0, bus.instr_valid}, 32'd0);
        check_val({tag, "_prst"}, {31'd0, bus.pc_reset_out}, 32'd1);
        check_val({tag, "_instr"}, {16'd0, bus.instr}, 32'd0);
    endtask

    task automatic leave_halt();
        bus.load_start = 1'b1;
        cycle();
        bus.load_start = 1'b0;
        check_val("to_load_prst", {31'd0, bus.pc_reset_out}, 32'd1);
        check_val("to_load_halted", {31'd0, bus.halted}, 32'd0);
    endtask

    task automatic wait_pc(input int v);
        int n = 0;
        while (bus.pc !== 16'(v) && n < 100) begin
            cycle();
            n++;
        end
        check_val("wait_pc", {16'd0, bus.pc}, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fetch_reset    = 1'b1;
        mon_en         = 1'b0;
        pc_force       = 1'b0;
        pc_force_val   = 16'd0;
        jmp_tgt        = 16'd0;
        bus.jump_flag  = 1'b0;
        bus.load_start = 1'b0;
        bus.load_done  = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = 16'd0;
        cycle();
        cycle();
        check_val("rst_instr", {16'd0, bus.instr}, 32'd0);
        check_val("rst_instr_pc", {16'd0, bus.instr_pc}, 32'd0);
        check_val("rst_vld", {31'd0, bus.instr_valid}, 32'd0);
        check_val("rst_prst", {31'd0, bus.pc_reset_out}, 32'd1);
        check_val("rst_halted", {31'd0, bus.halted}, 32'd0);
        check_val("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
        fetch_reset = 1'b0;
        mon_en      = 1'b1;

        // Full program, straight-line to halt.
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = 16'h1000 + 16'(i);
            wr(ADDR_W'(i), exp_mem[i]);
        end
        start_run(LAST_ADDR);
        cycle();
        check_val("first_vld", {31'd0, bus.instr_valid}, 32'd1);
        drain_and_halt("seq");

        // Jump at pc=5 to 20, then a jump at pc=27 must not halt.
        leave_halt();
        start_run(4);
        wait_pc(5);
        bus.jump_flag = 1'b1;
        jmp_tgt       = 16'd20;
        push_range(20, 26);
        cycle();
        bus.jump_flag = 1'b0;
        check_val("jmp_squash", {31'd0, bus.instr_valid}, 32'd0);
        wait_pc(27);
        bus.jump_flag = 1'b1;
        jmp_tgt       = 16'd10;
        push_range(10, LAST_ADDR);
        cycle();
        bus.jump_flag = 1'b0;
        check_val("jmp27_squash", {31'd0, bus.instr_valid}, 32'd0);
        check_val("jmp27_no_halt", {31'd0, bus.halted}, 32'd0);
        check_val("jmp27_prst", {31'd0, bus.pc_reset_out}, 32'd0);
        drain_and_halt("jmp");

        // Out-of-range pc sets a sticky fault; load_start in RUN clears it and squashes.
        leave_halt();
        start_run(-1);
        pc_force     = 1'b1;
        pc_force_val = 16'd30;
        cycle();
        check_val("oor_vld", {31'd0, bus.instr_valid}, 32'd0);
        check_val("oor_fault", {31'd0, bus.fetch_fault}, 32'd1);
        pc_force_val = 16'd7;
        push_exp(7);
        cycle();
        check_val("fault_sticky", {31'd0, bus.fetch_fault}, 32'd1);
        pc_force_val   = 16'd8;
        bus.load_start = 1'b1;
        cycle();
        bus.load_start = 1'b0;
        pc_force       = 1'b0;
        check_val("ls_run_vld", {31'd0, bus.instr_valid}, 32'd0);
        check_val("ls_run_prst", {31'd0, bus.pc_reset_out}, 32'd1);
        check_val("ls_run_fault_clr", {31'd0, bus.fetch_fault}, 32'd0);

        // LOAD writes: out-of-range dropped, load_start ignored, load_done wins, same-cycle write lands.
        wr(ADDR_W'(29), 16'hBEEF);
        wr(ADDR_W'(3), 16'hBEEF);
        exp_mem[3] = 16'hBEEF;
        bus.load_start = 1'b1;
        cycle();
        bus.load_start = 1'b0;
        check_val("ls_in_load_prst", {31'd0, bus.pc_reset_out}, 32'd1);
        check_val("ls_in_load_halted", {31'd0, bus.halted}, 32'd0);
        bus.load_start = 1'b1;
        bus.prog_we    = 1'b1;
        bus.prog_addr  = ADDR_W'(4);
        bus.prog_data  = 16'hCAFE;
        exp_mem[4]     = 16'hCAFE;
        start_run(LAST_ADDR);
        bus.load_start = 1'b0;
        bus.prog_addr  = ADDR_W'(5);
        bus.prog_data  = 16'hDEAD;
        cycle();
        bus.prog_we    = 1'b0;
        drain_and_halt("reload");

        // Asynchronous reset mid-run, then memory must still hold the program.
        leave_halt();
        start_run(2);
        cycle();
        cycle();
        cycle();
        check_val("pre_rst_vld", {31'd0, bus.instr_valid}, 32'd1);
        #3;
        fetch_reset = 1'b1;
        #1;
        check_val("arst_instr", {16'd0, bus.instr}, 32'd0);
        check_val("arst_vld", {31'd0, bus.instr_valid}, 32'd0);
        check_val("arst_prst", {31'd0, bus.pc_reset_out}, 32'd1);
        check_val("arst_halted", {31'd0, bus.halted}, 32'd0);
        cycle();
        fetch_reset = 1'b0;
        cycle();
        start_run(LAST_ADDR);
        drain_and_halt("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
